// File: rtl/decoder_scan_sequencer_if.sv
// decoder_scan_sequencer_if: control inputs and decoder-side outputs of the scan sequencer (dir exists only with SCAN_DIR_EN)
interface decoder_scan_sequencer_if #(parameter int DWELL_W = 8);
  logic               start;
  logic               stop;
  logic               one_shot;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         skip_mask;
`ifdef SCAN_DIR_EN
  logic               dir;
`endif
  logic [1:0]         Din;
  logic               En;
  logic               busy;
  logic               done;
`ifdef SCAN_DIR_EN
  modport master (output start, stop, one_shot, dwell, skip_mask, dir, input Din, En, busy, done);
  modport slave  (input start, stop, one_shot, dwell, skip_mask, dir, output Din, En, busy, done);
`else
  modport master (output start, stop, one_shot, dwell, skip_mask, input Din, En, busy, done);
  modport slave  (input start, stop, one_shot, dwell, skip_mask, output Din, En, busy, done);
`endif
endinterface

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: steps a 2-bit decoder select through unmasked indices with a programmable dwell; SCAN_DIR_EN adds a downward-scan dir input
module decoder_scan_sequencer #(parameter int DWELL_W = 8) (
  input logic                    clk,
  input logic                    rst,
  decoder_scan_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t             r_state, w_state;
  logic [1:0]         r_din, w_din, w_adv;
  logic [DWELL_W-1:0] r_cnt, w_cnt, r_dwell, w_dwell, w_dwell_in_m1, w_dwell_q_m1;
  logic [3:0]         r_mask, w_mask;
  logic               r_one_shot, w_one_shot, r_dir, w_dir, w_dir_in, w_wrap;
  function automatic logic [1:0] f_next(input logic [1:0] idx, input logic [3:0] m, input logic dn);
    logic [1:0] n, j;
    n = idx;
    for (int k = 4; k >= 1; k--) begin
      j = dn ? idx - 2'(k) : idx + 2'(k);
      if (!m[j]) n = j;
    end
    return n;
  endfunction
`ifdef SCAN_DIR_EN
  assign w_dir_in = bus.dir;
`else
  assign w_dir_in = 1'b0;
`endif
  assign w_dwell_in_m1 = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
  assign w_dwell_q_m1  = (r_dwell == '0) ? '0 : r_dwell - DWELL_W'(1);
  assign w_adv         = f_next(r_din, r_mask, r_dir);
  assign w_wrap        = r_dir ? (w_adv >= r_din) : (w_adv <= r_din);
  assign bus.Din       = r_din;
  assign bus.En        = (r_state == RUN);
  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == FINISH);
  // next-state: start latch/load in IDLE, dwell countdown and advance/wrap in RUN, single-cycle FINISH
  always_comb begin
    w_state    = r_state;
    w_din      = r_din;
    w_cnt      = r_cnt;
    w_dwell    = r_dwell;
    w_mask     = r_mask;
    w_one_shot = r_one_shot;
    w_dir      = r_dir;
    case (r_state)
      IDLE: if (bus.start && bus.skip_mask != 4'hf) begin
        w_state    = RUN;
        w_dwell    = bus.dwell;
        w_mask     = bus.skip_mask;
        w_one_shot = bus.one_shot;
        w_dir      = w_dir_in;
        w_din      = w_dir_in ? f_next(2'd0, bus.skip_mask, 1'b1) : f_next(2'd3, bus.skip_mask, 1'b0);
        w_cnt      = w_dwell_in_m1;
      end
      RUN: if (bus.stop) w_state = IDLE;
      else if (r_cnt == '0) begin
        if (w_wrap && r_one_shot) w_state = FINISH;
        else begin
          w_din = w_adv;
          w_cnt = w_dwell_q_m1;
        end
      end else w_cnt = r_cnt - DWELL_W'(1);
      default: w_state = IDLE;
    endcase
  end
  // state and latched-configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_din      <= 2'b00;
      r_cnt      <= '0;
      r_dwell    <= '0;
      r_mask     <= 4'h0;
      r_one_shot <= 1'b0;
      r_dir      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_din      <= w_din;
      r_cnt      <= w_cnt;
      r_dwell    <= w_dwell;
      r_mask     <= w_mask;
      r_one_shot <= w_one_shot;
      r_dir      <= w_dir;
    end
  end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: directed scan sequences with hand-computed Din/En/busy/done expectations
module tb_decoder_scan_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  decoder_scan_sequencer_if #(.DWELL_W(8)) bus ();
  decoder_scan_sequencer #(.DWELL_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_o(input string tag, input logic [1:0] din, input logic en, input logic dn);
    chk({tag, ".Din"}, 8'(bus.Din), 8'(din));
    chk({tag, ".En"}, 8'(bus.En), 8'(en));
    chk({tag, ".busy"}, 8'(bus.busy), 8'(en));
    chk({tag, ".done"}, 8'(bus.done), 8'(dn));
  endtask
  initial begin
    bus.start = 1'b1; bus.stop = 1'b0; bus.one_shot = 1'b0; bus.dwell = 8'd3; bus.skip_mask = 4'h0;
`ifdef SCAN_DIR_EN
    bus.dir = 1'b0;
`endif
    step();
    chk_o("rst0", 2'd0, 1'b0, 1'b0);
    step();
    chk_o("rst1", 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_o("start_lat", 2'd0, 1'b1, 1'b0);
    bus.start = 1'b0;
    for (int i = 1; i < 14; i++) begin
      step();
      chk_o($sformatf("free%0d", i), 2'((i / 3) % 4), 1'b1, 1'b0);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_o("free_stop", 2'd0, 1'b0, 1'b0);
    bus.one_shot = 1'b1; bus.dwell = 8'd2; bus.skip_mask = 4'b0101; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_o("os0", 2'd1, 1'b1, 1'b0);
    step(); chk_o("os1", 2'd1, 1'b1, 1'b0);
    step(); chk_o("os2", 2'd3, 1'b1, 1'b0);
    step(); chk_o("os3", 2'd3, 1'b1, 1'b0);
    step(); chk_o("os_fin", 2'd3, 1'b0, 1'b1);
    bus.start = 1'b1; bus.one_shot = 1'b0; bus.dwell = 8'd5; bus.skip_mask = 4'h0;
    step(); chk_o("fin_ign", 2'd3, 1'b0, 1'b0);
    step(); chk_o("restart", 2'd0, 1'b1, 1'b0);
    bus.start = 1'b0;
    step(10); chk_o("d2_c1", 2'd2, 1'b1, 1'b0);
    step(2);  chk_o("d2_c3", 2'd2, 1'b1, 1'b0);
    bus.stop = 1'b1;
    step(); chk_o("stop", 2'd2, 1'b0, 1'b0);
    bus.stop = 1'b0;
    step(); chk_o("stop_idle", 2'd2, 1'b0, 1'b0);
    bus.start = 1'b1;
    step(); chk_o("stop_rst", 2'd0, 1'b1, 1'b0);
    bus.start = 1'b0; bus.stop = 1'b1;
    step();
    bus.stop = 1'b0; bus.dwell = 8'd0; bus.start = 1'b1;
    step(); chk_o("dw0_0", 2'd0, 1'b1, 1'b0);
    bus.start = 1'b0;
    step(); chk_o("dw0_1", 2'd1, 1'b1, 1'b0);
    step(); chk_o("dw0_2", 2'd2, 1'b1, 1'b0);
    step(); chk_o("dw0_3", 2'd3, 1'b1, 1'b0);
    bus.skip_mask = 4'hf; bus.one_shot = 1'b1; bus.dwell = 8'd9;
    step(); chk_o("dw0_wrap", 2'd0, 1'b1, 1'b0);
    step(); chk_o("mask_ign", 2'd1, 1'b1, 1'b0);
    bus.stop = 1'b1;
    step(); chk_o("stop_prio", 2'd1, 1'b0, 1'b0);
    bus.stop = 1'b0; bus.start = 1'b1;
    step(); chk_o("all_mask0", 2'd1, 1'b0, 1'b0);
    step(); chk_o("all_mask1", 2'd1, 1'b0, 1'b0);
    bus.start = 1'b0;
    bus.skip_mask = 4'b1011; bus.one_shot = 1'b0; bus.dwell = 8'd2; bus.start = 1'b1;
    step(); chk_o("single0", 2'd2, 1'b1, 1'b0);
    bus.start = 1'b0;
    step(3); chk_o("single3", 2'd2, 1'b1, 1'b0);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
`ifdef SCAN_DIR_EN
    bus.dir = 1'b1; bus.one_shot = 1'b1; bus.dwell = 8'd1; bus.skip_mask = 4'b1000; bus.start = 1'b1;
    step(); chk_o("dir0", 2'd2, 1'b1, 1'b0);
    bus.start = 1'b0;
    step(); chk_o("dir1", 2'd1, 1'b1, 1'b0);
    step(); chk_o("dir2", 2'd0, 1'b1, 1'b0);
    step(); chk_o("dir_fin", 2'd0, 1'b0, 1'b1);
    step(); chk_o("dir_idle", 2'd0, 1'b0, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
